// File: rtl/seq_divider64_pkg.sv
// seq_divider64_pkg: shared width, state encoding and constants for the iterative signed divider.
package seq_divider64_pkg;
   localparam int DIV_WIDTH = 64;
   localparam logic [DIV_WIDTH-1:0] MIN_NEG = 64'h8000_0000_0000_0000;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
   typedef logic [5:0] cnt_t;
endpackage

// File: rtl/seq_divider64_div_step.sv
// seq_divider64_div_step: one restoring-division step, 65-bit compare-and-subtract.
module seq_divider64_div_step
   import seq_divider64_pkg::*;
#(
   parameter int W = DIV_WIDTH
) (
   input  logic [W:0]   rem_sh_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] rem_o,
   output logic         q_o
);
   // rem_sh_i < 2*dvs_i always holds, so the difference fits in W bits
   assign q_o   = rem_sh_i >= {1'b0, dvs_i};
   assign rem_o = q_o ? rem_sh_i[W-1:0] - dvs_i : rem_sh_i[W-1:0];
endmodule

// File: rtl/seq_divider64.sv
// seq_divider64: 64-bit signed truncating divider, one quotient bit per clock,
// start/done handshake with divide-by-zero and overflow flags.
module seq_divider64
   import seq_divider64_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DZ,
   output logic             OF
);
   state_e state_q;
   cnt_t cnt_q;
   logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, q_q, r_q, rem_d, abs_a, abs_b;
   logic qneg_q, rneg_q, busy_q, done_q, dz_q, of_q, qbit_d;
   assign abs_a = A[WIDTH-1] ? -A : A;
   assign abs_b = B[WIDTH-1] ? -B : B;
   seq_divider64_div_step #(.W(WIDTH)) u_step (
      .rem_sh_i({rem_q, dvd_q[WIDTH-1]}),
      .dvs_i(dvs_q),
      .rem_o(rem_d),
      .q_o(qbit_d)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         of_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               busy_q <= 1'b1;
               if (B == '0) begin
                  q_q     <= '1;
                  r_q     <= A;
                  dz_q    <= 1'b1;
                  of_q    <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  dvd_q   <= abs_a;
                  dvs_q   <= abs_b;
                  rem_q   <= '0;
                  qneg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                  rneg_q  <= A[WIDTH-1];
                  cnt_q   <= 6'd63;
                  dz_q    <= 1'b0;
                  of_q    <= (A == MIN_NEG) && (B == '1);
                  state_q <= CALC;
               end
            end
            CALC: begin
               rem_q   <= rem_d;
               dvd_q   <= {dvd_q[WIDTH-2:0], qbit_d};
               cnt_q   <= cnt_q - 6'd1;
               state_q <= (cnt_q == '0) ? FIX : CALC;
            end
            FIX: begin
               q_q     <= qneg_q ? -dvd_q : dvd_q;
               r_q     <= rneg_q ? -rem_q : rem_q;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign Q    = q_q;
   assign R    = r_q;
   assign DZ   = dz_q;
   assign OF   = of_q;
endmodule

// File: tb/tb_seq_divider64.sv
// tb_seq_divider64: directed self-checking bench for seq_divider64 using immediate assertions.
module tb_seq_divider64;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [63:0] A = '0, B = '0, Q, R;
   logic busy, done, DZ, OF;
   int total = 0, fails = 0;

   seq_divider64 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Q(Q), .R(R), .DZ(DZ), .OF(OF)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] eq, input logic [63:0] er,
                      input logic edz, input logic eof, input int elat);
      int n;
      logic busy_low;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      busy_low = 1'b0;
      while (done !== 1'b1 && n < 200) begin
         if (busy !== 1'b1) busy_low = 1'b1;
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(elat));
      chk({tag, "_busy_during"}, {63'd0, busy_low}, 64'd0);
      chk({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
      chk({tag, "_Q"}, Q, eq);
      chk({tag, "_R"}, R, er);
      chk({tag, "_DZ"}, {63'd0, DZ}, {63'd0, edz});
      chk({tag, "_OF"}, {63'd0, OF}, {63'd0, eof});
      @(negedge clk);
      chk({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_Q"}, Q, 64'd0);
      chk({tag, "_R"}, R, 64'd0);
      chk({tag, "_flags"}, {62'd0, DZ, OF}, 64'd0);
   endtask

   initial begin
      int pulses, lat;
      logic done_seen;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run("pp", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 65);
      run("np", -64'sd100, 64'd7, -64'sd14, -64'sd2, 1'b0, 1'b0, 65);
      run("pn", 64'd100, -64'sd7, -64'sd14, 64'd2, 1'b0, 1'b0, 65);
      run("nn", -64'sd100, -64'sd7, 64'd14, -64'sd2, 1'b0, 1'b0, 65);
      run("small", 64'd5, 64'd10, 64'd0, 64'd5, 1'b0, 1'b0, 65);
      run("big", 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'h3FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 65);
      run("dz", 64'd12345, 64'd0, '1, 64'd12345, 1'b1, 1'b0, 0);
      run("of", 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1, 65);
      run("after_of", 64'd7, 64'd2, 64'd3, 64'd1, 1'b0, 1'b0, 65);

      // start pulses and operand changes while busy must be ignored
      @(negedge clk);
      A = 64'd50; B = 64'd5; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pulses = 0;
      lat = -1;
      for (int i = 0; i < 80; i++) begin
         start = (i < 60) && i[0];
         A = 64'd9; B = 64'd3;
         if (done === 1'b1) begin
            pulses++;
            lat = i;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("ign_pulses", 64'(pulses), 64'd1);
      chk("ign_latency", 64'(lat), 64'd65);
      chk("ign_Q", Q, 64'd10);
      chk("ign_R", R, 64'd0);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      A = 64'd1000; B = 64'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) done_seen = 1'b1;
      end
      rst_n = 1'b1;
      repeat (70) begin
         @(negedge clk);
         if (done === 1'b1) done_seen = 1'b1;
      end
      chk("midrst_no_done", {63'd0, done_seen}, 64'd0);
      run("post_rst", -64'sd1000, 64'd3, -64'sd333, -64'sd1, 1'b0, 1'b0, 65);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
